riscv_muldiv: RTL and testbench

RISCV_MULDIV -- requirements
Module: riscv_muldiv

---
 rtl/riscv_muldiv.sv | 118 +++++++++++
 tb/tb_riscv_muldiv.sv | 123 ++++++++++++
 2 files changed

// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative signed multiply/divide unit (MULL, MULH, DIV, REM)
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       request handshake; ready only in IDLE
//   req_op_i, req_a_i, req_b_i    op code and operands, captured on accept
//   resp_valid_o/resp_ready_i     response handshake; valid only in DONE
//   resp_p_o                      registered result
//   busy_o                        high whenever the unit is not IDLE
module riscv_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_op_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_p_o,
    output logic             busy_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] OP_MULL = 4'd10;
    localparam logic [3:0] OP_MULH = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_REM  = 4'd13;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
    logic             neg_q, neg_d, sa_q, sa_d;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             req_div, is_div;
    logic [WIDTH:0]   sum, shl, diff;
    logic [2*WIDTH-1:0] prod_n;
    assign req_ready_o  = state_q == IDLE;
    assign resp_valid_o = state_q == DONE;
    assign busy_o       = state_q != IDLE;
    assign resp_p_o     = res_q;
    always_comb begin
        mag_a   = req_a_i[WIDTH-1] ? -req_a_i : req_a_i;
        mag_b   = req_b_i[WIDTH-1] ? -req_b_i : req_b_i;
        req_div = req_op_i == OP_DIV || req_op_i == OP_REM;
        is_div  = op_q == OP_DIV || op_q == OP_REM;
        // multiply step: conditionally add multiplicand to the high half, then shift right
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        // divide step: shift next dividend bit into the partial remainder and trial-subtract
        shl     = {hi_q, lo_q[WIDTH-1]};
        diff    = shl - {1'b0, m_q};
        prod_n  = -{hi_q, lo_q};
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                op_d    = req_op_i;
                sa_d    = req_a_i[WIDTH-1];
                neg_d   = req_a_i[WIDTH-1] ^ req_b_i[WIDTH-1];
                m_d     = req_div ? mag_b : mag_a;
                lo_d    = req_div ? mag_a : mag_b;
                hi_d    = '0;
                cnt_d   = CW'(WIDTH - 1);
                state_d = CALC;
            end
            CALC: begin
                cnt_d = cnt_q - 1'b1;
                // a borrow (diff MSB set) means the trial subtraction is restored
                hi_d  = is_div ? (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
                lo_d  = is_div ? {lo_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                // divide by zero yields an all-ones quotient and |A| as remainder naturally
                res_d   = op_q == OP_MULL ? (neg_q ? prod_n[WIDTH-1:0] : lo_q) :
                          op_q == OP_MULH ? (neg_q ? prod_n[2*WIDTH-1:WIDTH] : hi_q) :
                          op_q == OP_DIV  ? (m_q == '0 ? '1 : neg_q ? -lo_q : lo_q) :
                          op_q == OP_REM  ? (sa_q ? -hi_q : hi_q) : '0;
                state_d = DONE;
            end
            DONE: if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
        end
    end
endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv: directed self-checking bench for riscv_muldiv
module tb_riscv_muldiv;
    logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, resp_ready = 1'b0;
    logic [3:0]  req_op = '0;
    logic [31:0] req_a = '0, req_b = '0;
    logic        req_ready, resp_valid, busy;
    logic [31:0] resp_p, held;
    int          total = 0, bad = 0, lat, stale;
    always #5 clk = ~clk;
    riscv_muldiv #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b), .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready), .resp_p_o(resp_p), .busy_o(busy)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 4'($urandom);
        req_a = $urandom;
        req_b = $urandom;
    endtask
    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!resp_valid && n < 40);
    endtask
    task automatic handshake(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask
    task automatic finish_op(input logic [31:0] exp, input string tag);
        int n;
        wait_resp(n);
        check({tag, "_latency"}, n, 33);
        check(tag, resp_p, exp);
        handshake(tag);
    endtask
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        @(negedge clk);
        start(op, a, b);
        finish_op(exp, tag);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_p", resp_p, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start(4'd10, 32'd7, 32'hFFFFFFFD);
        finish_op(32'hFFFFFFEB, "mull_7xm3");
        run_op(4'd11, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min_min");
        run_op(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1_m1");
        run_op(4'd11, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, "mulh_max_max");
        run_op(4'd12, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_m7_2");
        run_op(4'd13, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_m7_2");
        run_op(4'd12, 32'd100, 32'd7, 32'd14, "div_100_7");
        run_op(4'd13, 32'd100, 32'hFFFFFFF9, 32'd2, "rem_100_m7");
        run_op(4'd12, 32'd100, 32'd0, 32'hFFFFFFFF, "div_by_zero");
        run_op(4'd13, 32'd100, 32'd0, 32'h00000064, "rem_by_zero");
        run_op(4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_overflow");
        run_op(4'd13, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_overflow");
        run_op(4'd3, 32'd5, 32'd6, 32'h00000000, "illegal_op");
        @(negedge clk);
        start(4'd10, 32'h12345678, 32'h10);
        wait_resp(lat);
        check("stall_latency", lat, 33);
        check("stall_p", resp_p, 32'h23456780);
        held = resp_p;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_p_stable", resp_p, held);
            check("stall_not_ready", 32'(req_ready), 32'd0);
        end
        handshake("stall");
        run_op(4'd12, 32'd21, 32'd5, 32'd4, "after_stall_div");
        @(negedge clk);
        start(4'd12, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(resp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid) stale++;
        end
        check("midrst_no_stale", stale, 0);
        run_op(4'd12, 32'd9, 32'd3, 32'd3, "div_9_3");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
